// File: rtl/pipes_pkg.sv
// Shared constants, colours and state type for the pipe obstacle layer.
package pipes_pkg;

  localparam int NUM_PIPES = 3;
  localparam int PIPE_W    = 96;
  localparam int GAP_H     = 200;
  localparam int SPACING   = 448;
  localparam int SPEED     = 2;
  localparam int BIRD_X    = 256;
  localparam int GAP_MIN   = 96;
  localparam int GAP_INIT  = 256;
  localparam int EDGE_W    = 4;
  localparam int SCREEN_W  = 1024;
  localparam int PIPE_X0   = 1024;

  localparam logic [11:0] COL_EDGE  = 12'h060;
  localparam logic [11:0] COL_BODY  = 12'h0A0;
  localparam logic [11:0] COL_BLANK = 12'h000;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } state_e;

  function automatic logic signed [11:0] init_x(input int k);
    return 12'(PIPE_X0 + k * SPACING);
  endfunction

endpackage

// File: rtl/pipe_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used to pick new gap heights.
module pipe_lfsr
  import pipes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] value
);

  logic [7:0] value_q, value_d;
  logic       fb;

  always_comb begin
    fb      = ^(value_q & LFSR_TAPS);
    value_d = value_q;
    // The all-zero lock-up state is unreachable from the seed; reseed if ever seen.
    if (en) value_d = (value_q == 8'h00) ? LFSR_SEED : {value_q[6:0], fb};
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= LFSR_SEED;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/draw_pipes.sv
// Scrolling pipe obstacles: game state, per-frame geometry update and a
// one-cycle compositor over the background pixel stream.
module draw_pipes
  import pipes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] vin_hcount_i,
  input  logic [10:0] vin_vcount_i,
  input  logic        vin_hsync_i,
  input  logic        vin_vsync_i,
  input  logic        vin_hblnk_i,
  input  logic        vin_vblnk_i,
  input  logic [11:0] rgb_i,
  input  logic        start_i,
  input  logic        game_over_i,
  output logic [10:0] vout_hcount_o,
  output logic [10:0] vout_vcount_o,
  output logic        vout_hsync_o,
  output logic        vout_vsync_o,
  output logic        vout_hblnk_o,
  output logic        vout_vblnk_o,
  output logic [11:0] rgb_o,
  output logic [35:0] pipe_x_o,
  output logic [29:0] gap_top_o,
  output logic        score_inc_o,
  output logic        running_o,
  output logic [1:0]  state_o
);

  localparam logic signed [11:0] SPEED_X  = 12'(SPEED);
  localparam logic signed [11:0] WRAP_LIM = 12'(-PIPE_W);
  localparam logic signed [11:0] WRAP_ADD = 12'(NUM_PIPES * SPACING);
  // A pipe is passed once its last column (x + PIPE_W - 1) drops below the bird.
  localparam logic signed [11:0] PASS_X   = 12'(BIRD_X - PIPE_W + 1);
  localparam logic signed [11:0] X_OFF    = 12'(SCREEN_W);
  localparam logic signed [12:0] W13      = 13'(PIPE_W);
  localparam logic signed [12:0] EDGE_LO  = 13'(EDGE_W);
  localparam logic signed [12:0] EDGE_HI  = 13'(PIPE_W - EDGE_W);

  state_e state_q, state_d;
  logic   vblnk_q, tick, advance, reload;
  logic [7:0] lfsr;

  logic signed [11:0] pipe_x_q [NUM_PIPES];
  logic signed [11:0] pipe_x_d [NUM_PIPES];
  logic signed [11:0] step_x   [NUM_PIPES];
  logic [9:0]         gap_q    [NUM_PIPES];
  logic [9:0]         gap_d    [NUM_PIPES];
  logic               score_q, score_d;

  logic [10:0] hcount_q, vcount_q;
  logic        hsync_q, vsync_q, hblnk_q, vblnk_out_q;
  logic [11:0] rgb_q, rgb_d;

  logic signed [12:0] h_s;
  logic signed [12:0] dx      [NUM_PIPES];
  logic [10:0]        gap_end [NUM_PIPES];
  logic [NUM_PIPES-1:0] hit;

  assign tick    = vin_vblnk_i & ~vblnk_q;
  assign advance = (state_q == ST_RUN) & tick;
  assign reload  = (state_q == ST_FROZEN) & start_i;

  pipe_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (tick),
    .value (lfsr)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start_i)     state_d = ST_RUN;
      ST_RUN:    if (game_over_i) state_d = ST_FROZEN;
      ST_FROZEN: if (start_i)     state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    running_o = (state_q == ST_RUN);
    state_o   = state_q;
  end

  always_comb begin
    score_d = 1'b0;
    for (int k = 0; k < NUM_PIPES; k++) begin
      pipe_x_d[k] = pipe_x_q[k];
      gap_d[k]    = gap_q[k];
      step_x[k]   = pipe_x_q[k] - SPEED_X;
      if (reload) begin
        pipe_x_d[k] = init_x(k);
        gap_d[k]    = 10'(GAP_INIT);
      end else if (advance) begin
        if (step_x[k] <= WRAP_LIM) begin
          pipe_x_d[k] = pipe_x_q[k] + WRAP_ADD;
          gap_d[k]    = 10'(GAP_MIN) + {2'b00, lfsr};
        end else begin
          pipe_x_d[k] = step_x[k];
        end
        if (pipe_x_q[k] >= PASS_X && pipe_x_d[k] < PASS_X) score_d = 1'b1;
      end
    end
  end

  always_comb begin
    h_s = $signed({2'b00, vin_hcount_i});
    for (int k = 0; k < NUM_PIPES; k++) begin
      dx[k]      = h_s - $signed({pipe_x_q[k][11], pipe_x_q[k]});
      gap_end[k] = {1'b0, gap_q[k]} + 11'(GAP_H);
      hit[k]     = (pipe_x_q[k] < X_OFF) && (dx[k] >= 13'sd0) && (dx[k] < W13) &&
                   ((vin_vcount_i < {1'b0, gap_q[k]}) || (vin_vcount_i >= gap_end[k]));
    end
  end

  // Walk from the highest index down so the lowest-index pipe wins on overlap.
  always_comb begin
    rgb_d = rgb_i;
    for (int k = NUM_PIPES - 1; k >= 0; k--) begin
      if (hit[k]) rgb_d = (dx[k] < EDGE_LO || dx[k] >= EDGE_HI) ? COL_EDGE : COL_BODY;
    end
    if (vin_hblnk_i || vin_vblnk_i) rgb_d = COL_BLANK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q     <= 1'b0;
      score_q     <= 1'b0;
      hcount_q    <= '0;
      vcount_q    <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      hblnk_q     <= 1'b0;
      vblnk_out_q <= 1'b0;
      rgb_q       <= '0;
      for (int k = 0; k < NUM_PIPES; k++) begin
        pipe_x_q[k] <= init_x(k);
        gap_q[k]    <= 10'(GAP_INIT);
      end
    end else begin
      vblnk_q     <= vin_vblnk_i;
      score_q     <= score_d;
      hcount_q    <= vin_hcount_i;
      vcount_q    <= vin_vcount_i;
      hsync_q     <= vin_hsync_i;
      vsync_q     <= vin_vsync_i;
      hblnk_q     <= vin_hblnk_i;
      vblnk_out_q <= vin_vblnk_i;
      rgb_q       <= rgb_d;
      for (int k = 0; k < NUM_PIPES; k++) begin
        pipe_x_q[k] <= pipe_x_d[k];
        gap_q[k]    <= gap_d[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_PIPES; k++) begin
      pipe_x_o[k*12 +: 12] = pipe_x_q[k];
      gap_top_o[k*10 +: 10] = gap_q[k];
    end
  end

  assign vout_hcount_o = hcount_q;
  assign vout_vcount_o = vcount_q;
  assign vout_hsync_o  = hsync_q;
  assign vout_vsync_o  = vsync_q;
  assign vout_hblnk_o  = hblnk_q;
  assign vout_vblnk_o  = vblnk_out_q;
  assign rgb_o         = rgb_q;
  assign score_inc_o   = score_q;

endmodule

// File: tb/tb_draw_pipes.sv
// Randomised bench for draw_pipes: driver pushes model predictions, a monitor
// pops one per cycle and compares against the registered outputs.
module tb_draw_pipes;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] vin_hcount = '0, vin_vcount = '0;
  logic        vin_hsync = 1'b0, vin_vsync = 1'b0, vin_hblnk = 1'b0, vin_vblnk = 1'b0;
  logic [11:0] rgb_in = '0;
  logic        start = 1'b0, game_over = 1'b0;
  logic [10:0] vout_hcount, vout_vcount;
  logic        vout_hsync, vout_vsync, vout_hblnk, vout_vblnk;
  logic [11:0] rgb_out;
  logic [35:0] pipe_x;
  logic [29:0] gap_top;
  logic        score_inc, running;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  draw_pipes dut (
    .clk           (clk),
    .rst           (rst),
    .vin_hcount_i  (vin_hcount),
    .vin_vcount_i  (vin_vcount),
    .vin_hsync_i   (vin_hsync),
    .vin_vsync_i   (vin_vsync),
    .vin_hblnk_i   (vin_hblnk),
    .vin_vblnk_i   (vin_vblnk),
    .rgb_i         (rgb_in),
    .start_i       (start),
    .game_over_i   (game_over),
    .vout_hcount_o (vout_hcount),
    .vout_vcount_o (vout_vcount),
    .vout_hsync_o  (vout_hsync),
    .vout_vsync_o  (vout_vsync),
    .vout_hblnk_o  (vout_hblnk),
    .vout_vblnk_o  (vout_vblnk),
    .rgb_o         (rgb_out),
    .pipe_x_o      (pipe_x),
    .gap_top_o     (gap_top),
    .score_inc_o   (score_inc),
    .running_o     (running),
    .state_o       (state_dbg)
  );

  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
    logic        score;
    logic        run;
    logic [35:0] px;
    logic [29:0] gt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: game state 0=idle 1=run 2=frozen, geometry as plain ints.
  int m_px[3];
  int m_gt[3];
  int m_lfsr;
  int m_state;
  bit m_vb_prev;

  function automatic int lfsr_next(input int v);
    return ((v << 1) & 255) | ($countones(v & 'hB8) & 1);
  endfunction

  function automatic logic [11:0] model_pix(input int h, input int v, input bit hb,
                                            input bit vb, input logic [11:0] rin);
    if (hb || vb) return 12'h000;
    for (int k = 0; k < 3; k++) begin
      if (m_px[k] < 1024 && h >= m_px[k] && h < m_px[k] + 96 &&
          (v < m_gt[k] || v >= m_gt[k] + 200))
        return (h - m_px[k] < 4 || h - m_px[k] >= 92) ? 12'h060 : 12'h0A0;
    end
    return rin;
  endfunction

  task automatic model_reload();
    for (int k = 0; k < 3; k++) begin
      m_px[k] = 1024 + 448 * k;
      m_gt[k] = 256;
    end
  endtask

  task automatic model_step();
    exp_t e;
    bit   tick;
    bit   sc;
    int   old;
    e = '0;
    if (rst) begin
      m_state   = 0;
      m_lfsr    = 'hA5;
      m_vb_prev = 1'b0;
      model_reload();
    end else begin
      e.hc  = vin_hcount;
      e.vc  = vin_vcount;
      e.hs  = vin_hsync;
      e.vs  = vin_vsync;
      e.hb  = vin_hblnk;
      e.vb  = vin_vblnk;
      e.rgb = model_pix(int'(vin_hcount), int'(vin_vcount), vin_hblnk, vin_vblnk, rgb_in);
      tick  = vin_vblnk && !m_vb_prev;
      m_vb_prev = vin_vblnk;
      sc = 1'b0;
      if (m_state == 1 && tick) begin
        for (int k = 0; k < 3; k++) begin
          old = m_px[k];
          if (old - 2 <= -96) begin
            m_px[k] = old + 1344;
            m_gt[k] = 96 + m_lfsr;
          end else begin
            m_px[k] = old - 2;
          end
          if (old + 95 >= 256 && m_px[k] + 95 < 256) sc = 1'b1;
        end
      end else if (m_state == 2 && start) begin
        model_reload();
      end
      case (m_state)
        0: if (start)     m_state = 1;
        1: if (game_over) m_state = 2;
        default: if (start) m_state = 0;
      endcase
      if (tick) m_lfsr = lfsr_next(m_lfsr);
      e.score = sc;
    end
    e.run = (m_state == 1);
    for (int k = 0; k < 3; k++) begin
      e.px[k*12 +: 12] = 12'(m_px[k]);
      e.gt[k*10 +: 10] = 10'(m_gt[k]);
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input int hc, input int vc, input bit hb, input bit vb,
                       input bit st, input bit go, input bit r);
    @(negedge clk);
    rst        = r;
    vin_hcount = 11'(hc);
    vin_vcount = 11'(vc);
    vin_hblnk  = hb;
    vin_vblnk  = vb;
    vin_hsync  = 1'($urandom_range(1, 0));
    vin_vsync  = 1'($urandom_range(1, 0));
    rgb_in     = 12'($urandom_range(4095, 0));
    start      = st;
    game_over  = go;
    model_step();
  endtask

  // Random pixels clustered around pipe 0, then nblank cycles of vertical blank.
  task automatic frame(input int npix, input int nblank);
    int lo, hi;
    for (int i = 0; i < npix; i++) begin
      lo = m_px[0] - 8;
      hi = m_px[0] + 104;
      if (m_px[0] >= 1024) begin
        lo = 900;
        hi = 1200;
      end
      if (lo < 0) lo = 0;
      if (hi > 2047) hi = 2047;
      drive(int'($urandom_range(hi, lo)), int'($urandom_range(767, 0)),
            $urandom_range(7, 0) == 0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < nblank; i++)
      drive(int'($urandom_range(2047, 0)), int'($urandom_range(767, 0)), 1'b0, 1'b1,
            1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 25) $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("vout", 64'({vout_hcount, vout_vcount, vout_hsync, vout_vsync, vout_hblnk, vout_vblnk}),
          64'({e.hc, e.vc, e.hs, e.vs, e.hb, e.vb}));
      chk("rgb_out", 64'(rgb_out), 64'(e.rgb));
      chk("score_inc", 64'(score_inc), 64'(e.score));
      chk("running", 64'(running), 64'(e.run));
      chk("pipe_x", 64'(pipe_x), 64'(e.px));
      chk("gap_top", 64'(gap_top), 64'(e.gt));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 3; i++) drive(int'($urandom_range(2047, 0)), 100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    // Idle frames: pipes parked off-screen, background passes through.
    frame(20, 2);
    frame(20, 2);
    drive(500, 100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(500, 100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int f = 0; f < 10; f++) frame(12, 2);
    // Pipe 0 now at 1004 with gap 256..455.
    drive(1010,  50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1010, 455, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1010, 456, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1010,  50, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1003, 100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1004, 100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1007, 100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1008, 100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1099, 100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1100, 100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Fast frames carry pipe 0 past the bird and through its wrap.
    for (int f = 0; f < 600; f++) begin
      if (f % 50 == 25) drive(300, 300, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      frame(1, 1);
    end
    for (int i = 0; i < 8; i++)
      drive(m_px[2] + i * 13, m_gt[2] + 196 + i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(300, 300, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int f = 0; f < 5; f++) frame(6, 2);
    drive(300, 300, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    frame(4, 2);
    drive(300, 300, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int f = 0; f < 3; f++) frame(6, 2);
    drive(300, 300, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(300, 300, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int f = 0; f < 4; f++) frame(6, 2);
    frame(3, 0);
    drive(700, 200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 3; f++) frame(6, 2);
    @(negedge clk);
    @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
